// File: rtl/cordic_spi_slave.sv
// cordic_spi_slave
//   SPI mode-0 slave front-end for the CORDIC engine. Pad-level sclk/mosi/cs_n
//   are synchronised into the i_clk domain. Command frames are decoded to
//   deliver angle words and a start strobe to the core. Latched cos/sin results
//   are serialised back on miso. The block also owns the data_ready flag.
//
//   Commands (first byte of a cs_n frame):
//     0x01  write angle: DATA_WIDTH_CORDIC bits follow, MSB first
//     0x02  read result: cos then sin, MSB first, starting on the next sclk fall
//     0x03  read status {data_ready, i_busy, overrun, 0...}
//           (only when CORDIC_SPI_STATUS_EN is defined)
//
//   Optional feature macro: CORDIC_SPI_STATUS_EN (sticky overrun bit and 0x03).
//
//   Ports:
//     i_clk, rst_n        system clock, synchronous active-low reset
//     sclk, mosi, cs_n    asynchronous SPI pad inputs
//     miso                SPI data out
//     data_ready          an unread CORDIC result is available
//     o_angle, o_start    angle word and one-cycle start strobe to the core
//     i_cos, i_sin        core results
//     i_done              one-cycle result-valid strobe
//     i_busy              core iterating
module cordic_spi_slave #(
  parameter int DATA_WIDTH_CORDIC = 16,
  parameter int DATA_WIDTH_SPI    = 8,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         i_clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         mosi,
  input  logic                         cs_n,
  output logic                         miso,
  output logic                         data_ready,
  output logic [DATA_WIDTH_CORDIC-1:0] o_angle,
  output logic                         o_start,
  input  logic [DATA_WIDTH_CORDIC-1:0] i_cos,
  input  logic [DATA_WIDTH_CORDIC-1:0] i_sin,
  input  logic                         i_done,
  input  logic                         i_busy
);

  localparam int TXW = 2 * DATA_WIDTH_CORDIC;
  localparam int CW  = $clog2(TXW + 1);

  localparam logic [CW-1:0] CMD_LAST = CW'(DATA_WIDTH_SPI - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(DATA_WIDTH_CORDIC - 1);
  localparam logic [CW-1:0] RD_FULL  = CW'(TXW);

  localparam logic [DATA_WIDTH_SPI-1:0] CMD_WR = DATA_WIDTH_SPI'(1);
  localparam logic [DATA_WIDTH_SPI-1:0] CMD_RD = DATA_WIDTH_SPI'(2);

  // COMMIT is the single cycle after the last angle bit is shifted in.
  typedef enum logic [2:0] {
    IDLE, CMD, WR_DATA, COMMIT, RD_DATA, DISCARD
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic sclk_d, cs_d;
  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [CW-1:0]                cnt;
  logic [DATA_WIDTH_CORDIC-1:0] rx;
  logic [DATA_WIDTH_CORDIC-1:0] rx_next;
  logic [DATA_WIDTH_SPI-1:0]    cmd_byte;
  logic [TXW-1:0]               tx;
  logic [CW-1:0]                rd_len;

  logic cnt_clr, rx_shift, tx_shift, snap, commit, drop;

  // The synchroniser outputs plus one extra sample form the edge detectors.
  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  assign rx_next  = {rx[DATA_WIDTH_CORDIC-2:0], mosi_s};
  assign cmd_byte = rx_next[DATA_WIDTH_SPI-1:0];

`ifdef CORDIC_SPI_STATUS_EN
  localparam logic [DATA_WIDTH_SPI-1:0] CMD_ST    = DATA_WIDTH_SPI'(3);
  localparam logic [CW-1:0]             RD_STATUS = CW'(DATA_WIDTH_SPI);
  logic snap_status;
  logic overrun;
`endif

  always_ff @(posedge i_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    rx_shift = 1'b0;
    tx_shift = 1'b0;
    snap     = 1'b0;
    commit   = 1'b0;
    drop     = 1'b0;
`ifdef CORDIC_SPI_STATUS_EN
    snap_status = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_clr = 1'b1;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rx_shift = 1'b1;
          if (cnt == CMD_LAST) begin
            cnt_clr = 1'b1;
            if (cmd_byte == CMD_WR) begin
              state_d = WR_DATA;
            end else if (cmd_byte == CMD_RD) begin
              state_d = RD_DATA;
              snap    = 1'b1;
`ifdef CORDIC_SPI_STATUS_EN
            end else if (cmd_byte == CMD_ST) begin
              state_d     = RD_DATA;
              snap_status = 1'b1;
`endif
            end else begin
              state_d = DISCARD;
            end
          end
        end
      end
      WR_DATA: begin
        if (sclk_rise) begin
          rx_shift = 1'b1;
          if (cnt == WR_LAST) state_d = COMMIT;
        end
      end
      COMMIT: begin
        // The word is complete here, so it commits even if cs_n is rising.
        commit  = ~i_busy;
        drop    = i_busy;
        state_d = DISCARD;
      end
      RD_DATA: begin
        if (sclk_fall) begin
          if (cnt == rd_len) state_d = DISCARD;
          else               tx_shift = 1'b1;
        end
      end
      DISCARD: state_d = DISCARD;
      default: state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      rx         <= '0;
      tx         <= '0;
      miso       <= 1'b0;
      data_ready <= 1'b0;
      o_angle    <= '0;
      o_start    <= 1'b0;
    end else begin
      o_start <= commit;
      if (commit) o_angle <= rx;

      if (cnt_clr)                   cnt <= '0;
      else if (rx_shift || tx_shift) cnt <= cnt + CW'(1);

      if (rx_shift) rx <= rx_next;

      if (snap) tx <= {i_cos, i_sin};
`ifdef CORDIC_SPI_STATUS_EN
      else if (snap_status)
        tx <= {data_ready, i_busy, overrun, {(DATA_WIDTH_SPI-3){1'b0}},
               {(TXW-DATA_WIDTH_SPI){1'b0}}};
`endif
      else if (tx_shift) tx <= {tx[TXW-2:0], 1'b0};

      // miso only carries data while a read is in progress; zero otherwise.
      if (tx_shift && state_d == RD_DATA) miso <= tx[TXW-1];
      else if (state_d != RD_DATA)        miso <= 1'b0;

      // A completion arriving with the read decode wins over the clear.
      if (i_done)    data_ready <= 1'b1;
      else if (snap) data_ready <= 1'b0;
    end
  end

`ifdef CORDIC_SPI_STATUS_EN
  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      rd_len  <= RD_FULL;
    end else begin
      if (drop)             overrun <= 1'b1;
      else if (snap_status) overrun <= 1'b0;
      if (snap)             rd_len <= RD_FULL;
      else if (snap_status) rd_len <= RD_STATUS;
    end
  end
`else
  assign rd_len = RD_FULL;
`endif

endmodule

// File: tb/tb_cordic_spi_slave.sv
// tb_cordic_spi_slave
//   Scoreboard bench for cordic_spi_slave. The SPI master tasks push every
//   received miso byte into got_byte_q; expected bytes and expected angles are
//   queued by the stimulus, and a monitor compares on each o_start pulse and
//   on each received byte.
module tb_cordic_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso;
  logic        data_ready;
  logic [15:0] o_angle;
  logic        o_start;
  logic [15:0] i_cos = '0;
  logic [15:0] i_sin = '0;
  logic        i_done = 1'b0;
  logic        i_busy = 1'b0;

  cordic_spi_slave #(
    .DATA_WIDTH_CORDIC(16),
    .DATA_WIDTH_SPI(8),
    .SYNC_STAGES(SYNC)
  ) dut (
    .i_clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .mosi(mosi),
    .cs_n(cs_n),
    .miso(miso),
    .data_ready(data_ready),
    .o_angle(o_angle),
    .o_start(o_start),
    .i_cos(i_cos),
    .i_sin(i_sin),
    .i_done(i_done),
    .i_busy(i_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int last_rise_cyc = 0;

  logic [15:0] exp_angle_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [7:0]  got_byte_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] data, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[7-i];
      wait_cyc(HALF);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      r = {r[6:0], miso};
      wait_cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] data, input logic [7:0] exp);
    logic [7:0] r;
    exp_byte_q.push_back(exp);
    spi_bits(data, 8, r);
    got_byte_q.push_back(r);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_cyc(4);
  endtask

  task automatic cs_high();
    wait_cyc(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(8);
  endtask

  // Bytes are packed MSB-first: byte i is bytes[39-8*i -: 8].
  task automatic frame(input int n, input logic [39:0] bytes, input logic [39:0] exp);
    cs_low();
    for (int i = 0; i < n; i++) spi_byte(bytes[39-8*i -: 8], exp[39-8*i -: 8]);
    cs_high();
  endtask

  task automatic pulse_done(input logic [15:0] c, input logic [15:0] s);
    i_cos  = c;
    i_sin  = s;
    i_done = 1'b1;
    wait_cyc(1);
    i_done = 1'b0;
  endtask

  // Monitor: compares on every o_start pulse and every received miso byte.
  always @(negedge clk) begin
    if (o_start === 1'b1) begin
      if (exp_angle_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL o_start_unexpected: got o_angle=%0h, expected no start", o_angle);
      end else begin
        logic [15:0] ea;
        ea = exp_angle_q.pop_front();
        check("o_angle", {16'h0, o_angle}, {16'h0, ea});
        check("o_start_latency", cyc - last_rise_cyc, SYNC + 2);
      end
    end
    while (got_byte_q.size() > 0) begin
      logic [7:0] g;
      g = got_byte_q.pop_front();
      if (exp_byte_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL miso_byte_unexpected: got %0h, expected none", g);
      end else begin
        logic [7:0] eb;
        eb = exp_byte_q.pop_front();
        check("miso_byte", {24'h0, g}, {24'h0, eb});
      end
    end
  end

  initial begin
    logic [7:0] r;

    // Reset state
    wait_cyc(3);
    check("rst_miso", miso, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_o_angle", o_angle, 0);
    check("rst_o_start", o_start, 0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Angle write
    exp_angle_q.push_back(16'h1234);
    frame(3, {8'h01, 8'h12, 8'h34, 16'h0}, 40'h0);
    check("angle_hold_1234", o_angle, 16'h1234);

    // Result read with snapshot taken at command decode
    pulse_done(16'h26DD, 16'h8000);
    check("data_ready_set", data_ready, 1);
    cs_low();
    spi_byte(8'h02, 8'h00);
    check("data_ready_clr", data_ready, 0);
    i_cos = 16'h0000;
    i_sin = 16'hFFFF;
    spi_byte(8'h00, 8'h26);
    spi_byte(8'h00, 8'hDD);
    spi_byte(8'h00, 8'h80);
    spi_byte(8'h00, 8'h00);
    cs_high();
    check("data_ready_after_read", data_ready, 0);

    // Write dropped while the core is busy
    i_busy = 1'b1;
    frame(3, {8'h01, 8'hAB, 8'hCD, 16'h0}, 40'h0);
    check("angle_kept_busy", o_angle, 16'h1234);
`ifdef CORDIC_SPI_STATUS_EN
    frame(2, {8'h03, 8'h00, 24'h0}, {8'h00, 8'h60, 24'h0});
    i_busy = 1'b0;
    frame(2, {8'h03, 8'h00, 24'h0}, {8'h00, 8'h00, 24'h0});
`else
    i_busy = 1'b0;
    frame(2, {8'h03, 8'h00, 24'h0}, {8'h00, 8'h00, 24'h0});
`endif

    // Partial angle frame, then a full one
    cs_low();
    spi_byte(8'h01, 8'h00);
    spi_byte(8'h55, 8'h00);
    spi_bits(8'hA0, 4, r);
    cs_high();
    check("angle_kept_partial", o_angle, 16'h1234);
    exp_angle_q.push_back(16'h0001);
    frame(3, {8'h01, 8'h00, 8'h01, 16'h0}, 40'h0);

    // Unknown command leaves data_ready alone
    pulse_done(16'h1111, 16'h2222);
    frame(4, {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h0}, 40'h0);
    check("data_ready_unknown", data_ready, 1);
    check("angle_kept_unknown", o_angle, 16'h0001);

    // Reset in the middle of an angle frame
    cs_low();
    spi_byte(8'h01, 8'h00);
    spi_bits(8'h50, 4, r);
    rst_n = 1'b0;
    wait_cyc(1);
    check("midrst_miso", miso, 0);
    check("midrst_data_ready", data_ready, 0);
    check("midrst_o_angle", o_angle, 0);
    check("midrst_o_start", o_start, 0);
    rst_n = 1'b1;
    cs_n  = 1'b1;
    wait_cyc(8);
    exp_angle_q.push_back(16'hFFFF);
    frame(3, {8'h01, 8'hFF, 8'hFF, 16'h0}, 40'h0);

    wait_cyc(20);
    check("angles_pending", exp_angle_q.size(), 0);
    check("bytes_pending", exp_byte_q.size(), 0);
    check("final_o_angle", o_angle, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
